// File: rtl/mem_access_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl_pkg
// Shared constants and types for the memory-stage access controller:
// FSM state encoding, datapath widths and a small alignment helper.
// -----------------------------------------------------------------------------
package mem_access_ctrl_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned WDOG_W = 8;

    // Memory access FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_e;

    // Halfword accesses require an even byte address.
    function automatic logic addr_aligned(input logic addr_lsb);
        return (addr_lsb == 1'b0);
    endfunction

endpackage : mem_access_ctrl_pkg

// File: rtl/wdog_counter.sv
// -----------------------------------------------------------------------------
// wdog_counter
// 8-bit watchdog counter used to bound the time spent waiting for memory.
// Ports:
//   clk   in  system clock
//   rst   in  asynchronous active-low reset
//   clr   in  synchronous clear (wins over en)
//   en    in  count enable
//   tc    out terminal count: counter value equals TIMEOUT-1
// -----------------------------------------------------------------------------
module wdog_counter
    import mem_access_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [WDOG_W-1:0] TC_VAL = WDOG_W'(TIMEOUT - 1);

    logic [WDOG_W-1:0] count_q;
    logic [WDOG_W-1:0] count_d;

    // Next count: clear has priority, otherwise increment when enabled.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + 8'd1;
        end else begin
            count_d = count_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = (count_q == TC_VAL);

endmodule : wdog_counter

// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
// Memory-stage access controller between the EX/MEM register and a
// multi-cycle stalling data memory. Latches the access, runs a request/done
// handshake, stalls the pipeline until the access retires, and flags
// misaligned accesses and memory timeouts.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   Addr, WrData             byte address / store data from execute
//   MemRead, MemWrite        access type held in EX/MEM
//   mem_addr, mem_wdata      address / write data to memory (0 outside REQ)
//   mem_rd, mem_wr           read / write request to memory
//   mem_rdata                read data from memory
//   mem_stall                memory did not accept the request this cycle
//   mem_done                 access complete, mem_rdata valid for reads
//   ReadData                 load result to MEM/WB (held until next read)
//   Stall                    freeze the earlier pipeline stages
//   err                      one-cycle pulse: misalignment or timeout
// -----------------------------------------------------------------------------
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] WrData,
    input  logic              MemRead,
    input  logic              MemWrite,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_stall,
    input  logic              mem_done,
    output logic [DATA_W-1:0] ReadData,
    output logic              Stall,
    output logic              err
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              op_wr_q, op_wr_d;
    logic              to_q, to_d;
    logic              mem_rd_q, mem_rd_d;
    logic              mem_wr_q, mem_wr_d;

    logic op_req_s;
    logic valid_op_s;
    logic misalign_s;
    logic wd_en_s;
    logic wd_tc_s;

    assign op_req_s   = MemRead | MemWrite;
    assign valid_op_s = op_req_s & addr_aligned(Addr[0]);
    assign misalign_s = op_req_s & ~addr_aligned(Addr[0]);

    // The watchdog only runs while waiting for mem_done; it is held clear
    // everywhere else so each WAIT visit starts from zero.
    assign wd_en_s = (state_q == WAIT);

    wdog_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk (clk),
        .rst (rst),
        .clr (~wd_en_s),
        .en  (wd_en_s),
        .tc  (wd_tc_s)
    );

    // Next-state, access latches, load result and timeout flag.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        op_wr_d = op_wr_q;
        rdata_d = rdata_q;
        to_d    = to_q;
        case (state_q)
            IDLE: begin
                to_d = 1'b0;
                if (valid_op_s) begin
                    addr_d  = Addr;
                    wdata_d = WrData;
                    // Read and write together is treated as a write.
                    op_wr_d = MemWrite;
                    state_d = REQ;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (mem_stall) begin
                    state_d = REQ;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_done) begin
                    if (!op_wr_q) begin
                        rdata_d = mem_rdata;
                    end else begin
                        rdata_d = rdata_q;
                    end
                    state_d = DONE;
                end else if (wd_tc_s) begin
                    rdata_d = 16'h0000;
                    to_d    = 1'b1;
                    state_d = DONE;
                end else begin
                    state_d = WAIT;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Memory bus outputs are computed from the next state so that the
    // registered request is asserted exactly while the FSM sits in REQ.
    always_comb begin
        mem_rd_d    = 1'b0;
        mem_wr_d    = 1'b0;
        mem_addr_d  = 16'h0000;
        mem_wdata_d = 16'h0000;
        if (state_d == REQ) begin
            mem_rd_d    = ~op_wr_d;
            mem_wr_d    = op_wr_d;
            mem_addr_d  = addr_d;
            mem_wdata_d = wdata_d;
        end else begin
            mem_rd_d    = 1'b0;
            mem_wr_d    = 1'b0;
            mem_addr_d  = 16'h0000;
            mem_wdata_d = 16'h0000;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            addr_q      <= 16'h0000;
            wdata_q     <= 16'h0000;
            op_wr_q     <= 1'b0;
            rdata_q     <= 16'h0000;
            to_q        <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= 16'h0000;
            mem_wdata_q <= 16'h0000;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            op_wr_q     <= op_wr_d;
            rdata_q     <= rdata_d;
            to_q        <= to_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign mem_rd    = mem_rd_q;
    assign mem_wr    = mem_wr_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign ReadData  = rdata_q;

    // Stall and err react in the same cycle as the op in EX/MEM, so they are
    // combinational; gating with rst forces both low while reset is held.
    assign Stall = rst & (((state_q == IDLE) & valid_op_s) |
                          (state_q == REQ) | (state_q == WAIT));
    assign err   = rst & (((state_q == IDLE) & misalign_s) |
                          ((state_q == DONE) & to_q));

endmodule : mem_access_ctrl
